// File: rtl/rf_scoreboard_if.sv
// Decode <-> scoreboard signal bundle: issue/source selects, write-back, flush,
// and the stall/pending/err view returned to decode.
interface rf_scoreboard_if #(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3
);
    logic                issueValid;
    logic                issueWriteEn;
    logic [SEL_W-1:0]    issueWriteRegSel;
    logic                src1Used;
    logic [SEL_W-1:0]    src1RegSel;
    logic                src2Used;
    logic [SEL_W-1:0]    src2RegSel;
    logic                wbWriteEn;
    logic [SEL_W-1:0]    wbWriteRegSel;
    logic                flush;
    logic                stall;
    logic [NUM_REGS-1:0] pending;
    logic                err;

    modport master (
        output issueValid, issueWriteEn, issueWriteRegSel,
               src1Used, src1RegSel, src2Used, src2RegSel,
               wbWriteEn, wbWriteRegSel, flush,
        input  stall, pending, err
    );

    modport slave (
        input  issueValid, issueWriteEn, issueWriteRegSel,
               src1Used, src1RegSel, src2Used, src2RegSel,
               wbWriteEn, wbWriteRegSel, flush,
        output stall, pending, err
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Decode-stage scoreboard: per-register count of in-flight writes, RAW/full
// stall generation and a sticky write-back underflow flag.
module rf_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3,
    parameter int CNT_W    = 2,
    parameter int BYPASS   = 1
) (
    input  logic           clk,
    input  logic           rst,
    rf_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]    count     [NUM_REGS];
    logic [CNT_W-1:0]    count_nxt [NUM_REGS];
    logic                err_reg;
    logic                err_nxt;

    logic [NUM_REGS-1:0] ret_hit;
    logic [NUM_REGS-1:0] issue_hit;
    logic [NUM_REGS-1:0] eff_busy;
    logic [NUM_REGS-1:0] at_max;
    logic                raw;
    logic                full;
    logic                stall_int;
    logic                issue_fire;

    always_comb begin
        ret_hit  = '0;
        eff_busy = '0;
        at_max   = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            ret_hit[r]  = sb.wbWriteEn && (sb.wbWriteRegSel == SEL_W'(r));
            at_max[r]   = (count[r] == CNT_MAX);
            // The oldest-and-only write retiring now is forwarded by the RF bypass
            eff_busy[r] = (count[r] != '0) &&
                          !((BYPASS != 0) && ret_hit[r] && (count[r] == CNT_ONE));
        end
    end

    always_comb begin
        raw        = (sb.src1Used && eff_busy[sb.src1RegSel]) ||
                     (sb.src2Used && eff_busy[sb.src2RegSel]);
        full       = sb.issueWriteEn && at_max[sb.issueWriteRegSel] &&
                     !ret_hit[sb.issueWriteRegSel];
        stall_int  = sb.issueValid && (raw || full);
        issue_fire = sb.issueValid && !stall_int && sb.issueWriteEn && !sb.flush;
        issue_hit  = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            issue_hit[r] = issue_fire && (sb.issueWriteRegSel == SEL_W'(r));
        end
    end

    always_comb begin
        err_nxt = err_reg;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            count_nxt[r] = count[r];
            if (sb.flush) begin
                count_nxt[r] = '0;
            end else if (issue_hit[r] && ret_hit[r]) begin
                count_nxt[r] = count[r];
            end else if (issue_hit[r]) begin
                count_nxt[r] = count[r] + CNT_ONE;
            end else if (ret_hit[r]) begin
                if (count[r] != '0) begin
                    count_nxt[r] = count[r] - CNT_ONE;
                end else begin
                    err_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                count[r] <= '0;
            end
            err_reg <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                count[r] <= count_nxt[r];
            end
            err_reg <= err_nxt;
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            sb.pending[r] = (count[r] != '0);
        end
    end

    assign sb.stall = stall_int;
    assign sb.err   = err_reg;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed vector bench for rf_scoreboard; one instance with BYPASS=1 and one
// with BYPASS=0 receive identical stimulus.
module tb_rf_scoreboard;
    typedef struct {
        logic       rst;
        logic       iv;
        logic       iwe;
        logic [2:0] isel;
        logic       s1u;
        logic [2:0] s1;
        logic       s2u;
        logic [2:0] s2;
        logic       wbe;
        logic [2:0] wbs;
        logic       fl;
        logic       chk;
        logic       xs_b;
        logic       xs_n;
        logic [7:0] xp;
        logic       xe;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic iv = 1'b0, iwe = 1'b0, s1u = 1'b0, s2u = 1'b0, wbe = 1'b0, fl = 1'b0;
    logic [2:0] isel = '0, s1 = '0, s2 = '0, wbs = '0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rf_scoreboard_if #(.NUM_REGS(8), .SEL_W(3)) ifb ();
    rf_scoreboard_if #(.NUM_REGS(8), .SEL_W(3)) ifn ();

    assign ifb.issueValid = iv;       assign ifn.issueValid = iv;
    assign ifb.issueWriteEn = iwe;    assign ifn.issueWriteEn = iwe;
    assign ifb.issueWriteRegSel = isel; assign ifn.issueWriteRegSel = isel;
    assign ifb.src1Used = s1u;        assign ifn.src1Used = s1u;
    assign ifb.src1RegSel = s1;       assign ifn.src1RegSel = s1;
    assign ifb.src2Used = s2u;        assign ifn.src2Used = s2u;
    assign ifb.src2RegSel = s2;       assign ifn.src2RegSel = s2;
    assign ifb.wbWriteEn = wbe;       assign ifn.wbWriteEn = wbe;
    assign ifb.wbWriteRegSel = wbs;   assign ifn.wbWriteRegSel = wbs;
    assign ifb.flush = fl;            assign ifn.flush = fl;

    rf_scoreboard #(.NUM_REGS(8), .SEL_W(3), .CNT_W(2), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .sb(ifb)
    );
    rf_scoreboard #(.NUM_REGS(8), .SEL_W(3), .CNT_W(2), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .sb(ifn)
    );

    function automatic vec_t mk(input int r, input int v, input int we, input int ws,
                                input int a1u, input int a1, input int a2u, input int a2,
                                input int we2, input int wsel, input int f, input int c,
                                input int sb_, input int sn, input int p, input int e);
        vec_t t;
        t.rst = 1'(r);    t.iv = 1'(v);     t.iwe = 1'(we);  t.isel = 3'(ws);
        t.s1u = 1'(a1u);  t.s1 = 3'(a1);    t.s2u = 1'(a2u); t.s2 = 3'(a2);
        t.wbe = 1'(we2);  t.wbs = 3'(wsel); t.fl = 1'(f);    t.chk = 1'(c);
        t.xs_b = 1'(sb_); t.xs_n = 1'(sn);  t.xp = 8'(p);    t.xe = 1'(e);
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    // Inputs change at negedge; stall reflects the current state, pending/err
    // reflect the state produced by earlier edges.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst; iv = v.iv; iwe = v.iwe; isel = v.isel;
        s1u = v.s1u; s1 = v.s1; s2u = v.s2u; s2 = v.s2;
        wbe = v.wbe; wbs = v.wbs; fl = v.fl;
        #2;
        if (v.chk) begin
            check("stall_byp", idx, {7'd0, ifb.stall}, {7'd0, v.xs_b});
            check("stall_nob", idx, {7'd0, ifn.stall}, {7'd0, v.xs_n});
            check("pending_byp", idx, ifb.pending, v.xp);
            check("pending_nob", idx, ifn.pending, v.xp);
            check("err_byp", idx, {7'd0, ifb.err}, {7'd0, v.xe});
            check("err_nob", idx, {7'd0, ifn.err}, {7'd0, v.xe});
        end
    endtask

    vec_t tbl[32];

    initial begin
        //             rst iv we ws s1u s1 s2u s2 wbe wbs fl chk sb sn pend  err
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        tbl[1]  = mk(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0);
        tbl[2]  = mk(1, 1, 0, 0, 1, 3, 1, 6, 0, 0, 0, 1, 0, 0, 8'h00, 0);
        tbl[3]  = mk(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0);
        tbl[4]  = mk(1, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 1, 1, 8'h08, 0);
        tbl[5]  = mk(1, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 1, 1, 8'h08, 0);
        tbl[6]  = mk(1, 1, 0, 0, 1, 3, 0, 0, 1, 3, 0, 1, 0, 1, 8'h08, 0);
        tbl[7]  = mk(1, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0);
        tbl[8]  = mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0);
        tbl[9]  = mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h20, 0);
        tbl[10] = mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h20, 0);
        tbl[11] = mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8'h20, 0);
        tbl[12] = mk(1, 1, 1, 5, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 8'h20, 0);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 8'h20, 0);
        tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 8'h20, 0);
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 8'h20, 0);
        tbl[16] = mk(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0);
        tbl[17] = mk(1, 1, 1, 2, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 8'h04, 0);
        tbl[18] = mk(1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 1, 1, 8'h04, 0);
        tbl[19] = mk(1, 1, 0, 0, 0, 0, 1, 2, 1, 2, 0, 1, 0, 1, 8'h04, 0);
        tbl[20] = mk(1, 1, 1, 4, 1, 4, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0);
        tbl[21] = mk(1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h10, 0);
        tbl[22] = mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h10, 0);
        tbl[23] = mk(1, 1, 1, 6, 1, 4, 0, 0, 1, 1, 1, 1, 1, 1, 8'h12, 0);
        tbl[24] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0);
        tbl[25] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 0, 0, 8'h00, 0);
        tbl[26] = mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 1);
        tbl[27] = mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8'h01, 1);
        tbl[28] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h01, 1);
        tbl[29] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 1);
        tbl[30] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 1);
        tbl[31] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0);

        for (int i = 0; i < 32; i++) begin
            apply(tbl[i], i);
        end

        // Reset edge coinciding with issue, retire and flush drops all state
        apply(mk(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0), 100);
        apply(mk(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h08, 0), 101);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 1, 0, 0, 8'h08, 0), 102);
        apply(mk(0, 1, 1, 3, 1, 3, 0, 0, 1, 3, 1, 1, 1, 1, 8'h08, 1), 103);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0), 104);

        // Idle after reset with arbitrary source reads never stalls
        for (int i = 0; i < 8; i++) begin
            apply(mk(1, 1, 0, 0, 1, int'($urandom_range(0, 7)), 1,
                     int'($urandom_range(0, 7)), 0, 0, 0, 1, 0, 0, 8'h00, 0), 200 + i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
